// File: rtl/pe_row_feeder.sv
// Input FIFO plus diagonal skew pipeline that feeds each PE array row its input_data/input_valid.
// Optional FEEDER_ZERO_PAD_EN: a lane that is not valid drives zero data instead of holding its last value.
module pe_row_feeder #(
  parameter int bw    = 4,
  parameter int row   = 8,
  parameter int depth = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [row*bw-1:0]       in_data,
  input  logic                    rd,
  output logic [row*bw-1:0]       out_data,
  output logic [row-1:0]          out_valid,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(depth):0]  count
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] depth_c = cw'(depth);

  logic [row*bw-1:0] mem [depth];
  logic [aw-1:0]     wr_ptr, rd_ptr;
  logic [cw-1:0]     count_q, count_d;
  logic              full_q, empty_q;
  logic              rd_acc, wr_acc;

  // Registered FIFO read port; this is the head of every lane's delay chain.
  logic [row*bw-1:0] pop_data;
  logic              pop_valid;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = rd & ~empty_q;
  assign wr_acc = wr & (~full_q | rd_acc);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + cw'(1);
      2'b01:   count_d = count_q - cw'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + aw'(1);
      if (rd_acc) rd_ptr <= rd_ptr + aw'(1);
      count_q <= count_d;
      full_q  <= (count_d == depth_c);
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers, so old contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= in_data;
  end

  // When full with a simultaneous write, wr_ptr == rd_ptr and the read still returns the old entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      pop_valid <= rd_acc;
      if (rd_acc) pop_data <= mem[rd_ptr];
    end
  end

  for (genvar i = 0; i < row; i++) begin : g_lane
    logic [bw-1:0] d_sr [i+1];
    logic [i:0]    v_sr;

    // Free-running chain of i+1 stages; data moves only alongside a valid.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_sr <= '0;
        for (int k = 0; k <= i; k++) d_sr[k] <= '0;
      end else begin
        v_sr[0] <= pop_valid;
        if (pop_valid) d_sr[0] <= pop_data[i*bw +: bw];
        for (int k = 1; k <= i; k++) begin
          v_sr[k] <= v_sr[k-1];
          if (v_sr[k-1]) d_sr[k] <= d_sr[k-1];
        end
      end
    end

    assign out_valid[i] = v_sr[i];
`ifdef FEEDER_ZERO_PAD_EN
    assign out_data[i*bw +: bw] = v_sr[i] ? d_sr[i] : '0;
`else
    assign out_data[i*bw +: bw] = d_sr[i];
`endif
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: tb/tb_pe_row_feeder.sv
// Self-checking bench for pe_row_feeder: queue/history reference model compared every cycle,
// plus directed literal checks for reset, single wavefront, full handling and mid-stream reset.
module tb_pe_row_feeder;
  localparam int bw    = 4;
  localparam int row   = 8;
  localparam int depth = 16;
  localparam int cw    = $clog2(depth) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr = 1'b0;
  logic              rd = 1'b0;
  logic [row*bw-1:0] in_data = '0;
  logic [row*bw-1:0] out_data;
  logic [row-1:0]    out_valid;
  logic              full, empty;
  logic [cw-1:0]     count;

  pe_row_feeder #(.bw(bw), .row(row), .depth(depth)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in_data(in_data), .rd(rd),
    .out_data(out_data), .out_valid(out_valid), .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, plus a history of which vector was popped at which edge.
  // Lane i after edge E shows whatever was popped at edge E-1-i.
  logic [row*bw-1:0] q[$];
  bit                hv [64];
  logic [row*bw-1:0] hd [64];
  int                ecnt = 1000;
  logic [row-1:0]    exp_v = '0;
  logic [row*bw-1:0] exp_d = '0;
  logic [row*bw-1:0] held  = '0;

  always @(posedge clk or negedge reset) begin : model
    bit ra, wa;
    int e;
    if (!reset) begin
      q.delete();
      for (int k = 0; k < 64; k++) hv[k] = 1'b0;
      held  = '0;
      exp_v = '0;
      exp_d = '0;
    end else begin
      ra = rd && (q.size() != 0);
      wa = wr && ((q.size() < depth) || ra);
      ecnt++;
      hv[ecnt % 64] = 1'b0;
      if (ra) begin
        hv[ecnt % 64] = 1'b1;
        hd[ecnt % 64] = q.pop_front();
      end
      if (wa) q.push_back(in_data);
      for (int i = 0; i < row; i++) begin
        e = ecnt - 1 - i;
        exp_v[i] = hv[e % 64];
        if (hv[e % 64]) held[i*bw +: bw] = hd[e % 64][i*bw +: bw];
`ifdef FEEDER_ZERO_PAD_EN
        exp_d[i*bw +: bw] = exp_v[i] ? held[i*bw +: bw] : '0;
`else
        exp_d[i*bw +: bw] = held[i*bw +: bw];
`endif
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model out_valid", 64'(out_valid), 64'(exp_v));
      check("model out_data",  64'(out_data),  64'(exp_d));
      check("model count",     64'(count),     64'(q.size()));
      check("model full",      64'(full),      64'(q.size() == depth));
      check("model empty",     64'(empty),     64'(q.size() == 0));
    end
  end

  bit            log_en = 1'b0;
  logic [bw-1:0] lane0_log[$];
  always @(negedge clk) if (log_en && out_valid[0]) lane0_log.push_back(out_data[bw-1:0]);

  bit stale_watch = 1'b0;
  int stale_cnt   = 0;
  always @(negedge clk) if (stale_watch && out_valid != '0) stale_cnt++;

  task automatic cyc(input bit w, input logic [row*bw-1:0] d, input bit r);
    @(negedge clk);
    #1;
    wr      = w;
    in_data = d;
    rd      = r;
  endtask

  initial begin
    logic [row-1:0]    ev;
    logic [row*bw-1:0] ed;
    logic [bw-1:0]     el;

    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data",  64'(out_data),  64'd0);
    check("reset empty",     64'(empty),     64'd1);
    check("reset full",      64'(full),      64'd0);
    check("reset count",     64'(count),     64'd0);
    #1 reset = 1'b1;

    // Reads on an empty FIFO are ignored.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0, 1'b1);
      check("idle out_valid", 64'(out_valid), 64'd0);
      check("idle empty",     64'(empty),     64'd1);
      check("idle count",     64'(count),     64'd0);
    end
    cyc(1'b0, '0, 1'b0);

    // Single vector wavefront: lane i valid exactly i+1 cycles after the pop edge.
    cyc(1'b1, 32'h7654_3210, 1'b0);
    cyc(1'b0, '0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, '0, 1'b0);
      ev = (k >= 1 && k <= row) ? row'(1) << (k - 1) : '0;
      ed = '0;
      for (int j = 0; j < row; j++) begin
`ifdef FEEDER_ZERO_PAD_EN
        if (j == k - 1) ed[j*bw +: bw] = bw'(j);
`else
        if (j <= k - 1) ed[j*bw +: bw] = bw'(j);
`endif
      end
      check("wave out_valid", 64'(out_valid), 64'(ev));
      check("wave out_data",  64'(out_data),  64'(ed));
    end

    // Fill to full; the 17th write is dropped.
    for (int i = 0; i < depth; i++) cyc(1'b1, (row*bw)'(i), 1'b0);
    cyc(1'b1, 32'hFF, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("fill full",  64'(full),  64'd1);
    check("fill count", 64'(count), 64'd16);

    // Full with simultaneous write and read, then drain everything.
    log_en = 1'b1;
    cyc(1'b1, 32'hAA, 1'b1);
    cyc(1'b0, '0, 1'b0);
    check("full wr+rd count", 64'(count), 64'd16);
    check("full wr+rd full",  64'(full),  64'd1);
    for (int i = 0; i < depth; i++) cyc(1'b0, '0, 1'b1);
    repeat (12) cyc(1'b0, '0, 1'b0);
    log_en = 1'b0;
    check("drain length", 64'(lane0_log.size()), 64'd17);
    for (int i = 0; i < 17; i++) begin
      el = (i < 16) ? bw'(i) : 4'hA;
      check("drain order", (i < lane0_log.size()) ? 64'(lane0_log[i]) : 64'hDEAD, 64'(el));
    end
    check("drain empty", 64'(empty), 64'd1);

    // Reset with reads in flight.
    for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("inflight lane0 valid", 64'(out_valid[0]), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst count",     64'(count),     64'd0);
    check("midrst empty",     64'(empty),     64'd1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    reset = 1'b1;
    stale_watch = 1'b1;
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1);
    stale_watch = 1'b0;
    check("post-reset stale valids", 64'(stale_cnt), 64'd0);
    check("post-reset count",        64'(count),     64'd0);

    // Randomized traffic: write-heavy phase to reach full, then read-heavy phase to drain.
    for (int i = 0; i < 600; i++) begin
      if (i < 300)
        cyc($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 35);
      else
        cyc($urandom_range(0, 99) < 35, $urandom, $urandom_range(0, 99) < 70);
    end
    repeat (12) cyc(1'b0, '0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_row_feeder.md
Name: pe_row_feeder

Overview:
- Upstream input stage for the PE array. Buffers packed input vectors, one lane per array row, in a FIFO.
- On each read, emits the vector as a diagonal wavefront: lane i is delayed i cycles, so each PE row receives input_data/input_valid in systolic order.
- Drives each PE row's input_data and input_valid directly.

Parameters:
- bw, 4, width of one lane element (matches PE input_data width)
- row, 8, number of lanes / PE array rows
- depth, 16, FIFO entries; must be a power of two, >= 2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- wr  input  1  write request; pushes in_data when accepted
- in_data  input  row*bw  packed vector; lane i = bits [(i+1)*bw-1 : i*bw]
- rd  input  1  read request; pops one vector into the skew pipeline when accepted
- out_data  output  row*bw  skewed lanes to PE rows; lane i to row i
- out_valid  output  row  per-lane valid; bit i drives row i input_valid
- full  output  1  count == depth
- empty  output  1  count == 0
- count  output  log2(depth)+1  current FIFO occupancy

Behaviour:
- Reset (reset low, asynchronous):
  - Clears read pointer, write pointer, count and all skew-stage registers.
  - Outputs: out_data=0, out_valid=0, full=0, empty=1, count=0.
  - FIFO RAM contents are don't-care.
- Reset asserted mid-operation discards all buffered and in-flight data. No lane emits a valid after reset deasserts until a new read is accepted.
- Read accept: rd_acc = rd & ~empty.
- Write accept: wr_acc = wr & (~full | rd_acc). A write while full is accepted only with a simultaneous accepted read.
- rd while empty: ignored, no state change, no valid generated.
- wr while full without an accepted read: vector dropped, no state change.
- count update each edge: +1 if write only, -1 if read only, unchanged if both or neither.
- full, empty and count are registered; they reflect state after the most recent edge.
- Pointers are log2(depth) bits and wrap from depth-1 to 0 naturally.
- Simultaneous wr_acc and rd_acc with count==1: the read returns the older entry and the new entry remains.
- Simultaneous wr_acc and rd_acc with count==0: not possible, since rd_acc requires ~empty. There is no write-through.
- Skew pipeline:
  - Lane i has a delay chain of i+1 registers holding data and valid.
  - An entry popped at edge N appears on lane 0 after edge N+1 and on lane i after edge N+1+i.
  - Lane row-1 shows it after edge N+row.
- Back-to-back reads at consecutive edges produce continuous valids on every lane, each lane offset by one cycle from its neighbour.
- Lane valid is low in any cycle with no corresponding entry. The delay chain keeps shifting regardless of rd and wr; it has no stall.
- With optional feature off, lane data holds the last shifted value while valid is low. Data only updates when its valid stage is loaded.
- No arithmetic on data; lanes pass through unmodified, width bw.

Optional Feature:
- Macro: FEEDER_ZERO_PAD_EN.
- Defined: any lane whose out_valid bit is 0 drives out_data lane = 0 in that cycle, giving zero-padded wavefront edges for the array.
- Undefined: an invalid lane holds its last valid value. Consumers must qualify the data with out_valid.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset low 3 cycles, release, rd=1 with FIFO empty for 5 cycles.
  - Required: out_valid stays 0, empty=1, count=0.
- Single vector, row=8, bw=4:
  - Stimulus: write 0x76543210, then rd one cycle.
  - Required: lane i shows value i with out_valid[i]=1 exactly at cycle rd+1+i, for one cycle each.
- Fill to full:
  - Stimulus: 16 writes of values 0..15, then a 17th write of 0xFF without rd.
  - Required: full=1, count=16, 0xFF is dropped. Draining 16 reads yields 0..15 in order on lane 0.
- Full with simultaneous wr and rd:
  - Stimulus: at count=16, one cycle of wr(0xAA) and rd.
  - Required: count stays 16, oldest entry is emitted, 0xAA is the last entry drained.
- Reset mid-stream:
  - Stimulus: 4 back-to-back reads in flight; assert reset at cycle 3.
  - Required: all out_valid drop immediately, count=0 after release, no stale valids appear afterward.
- FEEDER_ZERO_PAD_EN:
  - Stimulus: single-vector test with the macro defined.
  - Required: every lane reads 0 when its out_valid is 0.
  - Without the macro: lane 0 holds 0x0 and lane 7 holds 0x7 after their valid pulses.
